// File: rtl/draw_scheduler.sv
// draw_scheduler: arbitrates N_REQ requesters onto one shared draw engine.
// Fixed priority (lowest index wins) by default; define DRAW_SCHED_ROUND_ROBIN_EN
// to switch to round-robin arbitration with a last-served pointer.
module draw_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_x,
  input  logic [7*N_REQ-1:0] req_y,
  output logic [N_REQ-1:0]   ack,
  output logic               eng_start,
  output logic [7:0]         eng_x,
  output logic [6:0]         eng_y,
  input  logic               eng_done,
  output logic [SEL_W-1:0]   sel,
  output logic               busy
);

  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 7;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RELEASE = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t             state;
  logic               any_req;
  logic [SEL_W-1:0]   win_idx;
  logic [X_W-1:0]     win_x;
  logic [Y_W-1:0]     win_y;
  logic [N_REQ-1:0]   sel_onehot;

`ifdef DRAW_SCHED_ROUND_ROBIN_EN
  logic [SEL_W-1:0]   rr_ptr;
  logic               rr_found;
  int unsigned        rr_idx;

  // Round-robin pick: scan starting one past the last served index.
  always_comb begin
    any_req  = |req;
    win_idx  = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      rr_idx = (32'(rr_ptr) + 32'd1 + k) % N_REQ;
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        win_idx  = SEL_W'(rr_idx);
      end
    end
  end
`else
  // Fixed-priority pick: lowest requesting index wins (index 0 is background).
  always_comb begin
    any_req = |req;
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) win_idx = SEL_W'(i);
    end
  end
`endif

  // Select the winner's origin and build the one-hot of the held grant.
  always_comb begin
    win_x      = '0;
    win_y      = '0;
    sel_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == SEL_W'(i)) begin
        win_x = req_x[X_W*i +: X_W];
        win_y = req_y[Y_W*i +: Y_W];
      end
      sel_onehot[i] = (sel == SEL_W'(i));
    end
  end

  // Grant/run/release/ack sequencer; grant fields are frozen from grant until ACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      eng_start <= 1'b0;
      ack       <= '0;
      busy      <= 1'b0;
      sel       <= '0;
      eng_x     <= '0;
      eng_y     <= '0;
`ifdef DRAW_SCHED_ROUND_ROBIN_EN
      rr_ptr    <= SEL_W'(N_REQ - 1);
`endif
    end else begin
      ack <= '0;
      case (state)
        S_IDLE: begin
          // An engine still signalling done has not returned idle: hold off.
          if (any_req && !eng_done) begin
            state     <= S_RUN;
            sel       <= win_idx;
            eng_x     <= win_x;
            eng_y     <= win_y;
            eng_start <= 1'b1;
            busy      <= 1'b1;
`ifdef DRAW_SCHED_ROUND_ROBIN_EN
            rr_ptr    <= win_idx;
`endif
          end
        end
        S_RUN: begin
          if (eng_done) begin
            state     <= S_RELEASE;
            eng_start <= 1'b0;
          end
        end
        S_RELEASE: begin
          if (!eng_done) begin
            state <= S_ACK;
            ack   <= sel_onehot;
          end
        end
        S_ACK: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          eng_start <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed testbench for draw_scheduler (N_REQ=4). Expectations follow the
// RR ordering when DRAW_SCHED_ROUND_ROBIN_EN is defined, fixed priority otherwise.
module tb_draw_scheduler;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  logic               clk;
  logic               reset;
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_x;
  logic [7*N_REQ-1:0] req_y;
  logic [N_REQ-1:0]   ack;
  logic               eng_start;
  logic [7:0]         eng_x;
  logic [6:0]         eng_y;
  logic               eng_done;
  logic [SEL_W-1:0]   sel;
  logic               busy;

  int tests_run;
  int tests_failed;

  draw_scheduler #(.N_REQ(N_REQ), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .ack(ack), .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .eng_done(eng_done), .sel(sel), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_origin(input int i, input logic [7:0] x, input logic [6:0] y);
    req_x[8*i +: 8] = x;
    req_y[7*i +: 7] = y;
  endtask

  // Engine reports done for one cycle then drops; leaves the DUT in ACK.
  task automatic finish_draw();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    tests_run++;
    if ({busy, eng_start, ack, sel, eng_x, eng_y} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b start=%b ack=%b sel=%0d x=%0d y=%0d want all 0",
               busy, eng_start, ack, sel, eng_x, eng_y);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int bad;
    set_origin(2, 8'd40, 7'd30);
    req = 4'b0100;
    step();
    tests_run++;
    if (!(sel === 2'd2 && eng_x === 8'd40 && eng_y === 7'd30 && eng_start === 1'b1 && busy === 1'b1)) begin
      tests_failed++;
      $display("FAIL single_grant: sel=%0d x=%0d y=%0d start=%b busy=%b want 2 40 30 1 1",
               sel, eng_x, eng_y, eng_start, busy);
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (eng_start !== 1'b1 || ack !== 4'b0000) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL single_run_hold: %0d bad cycles want 0", bad);
    end
    eng_done = 1'b1;
    step();
    tests_run++;
    if (eng_start !== 1'b0 || ack !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_release: start=%b ack=%b want 0 0000", eng_start, ack);
    end
    eng_done = 1'b0;
    step();
    req = 4'b0000;
    tests_run++;
    if (ack !== 4'b0100) begin
      tests_failed++;
      $display("FAIL single_ack: ack=%b want 0100", ack);
    end
    step();
    tests_run++;
    if (ack !== 4'b0000 || busy !== 1'b0 || eng_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_after_ack: ack=%b busy=%b start=%b want 0000 0 0", ack, busy, eng_start);
    end
  endtask

  task automatic test_handshake();
    req = 4'b0001;
    step();
    step();
    eng_done = 1'b1;
    step();
    // RELEASE cycle 1: done still high
    tests_run++;
    if (eng_start !== 1'b0 || busy !== 1'b1 || ack !== 4'b0000) begin
      tests_failed++;
      $display("FAIL hs_release1: start=%b busy=%b ack=%b want 0 1 0000", eng_start, busy, ack);
    end
    step();
    eng_done = 1'b0;
    // RELEASE cycle 2: done now low
    tests_run++;
    if (eng_start !== 1'b0 || busy !== 1'b1 || ack !== 4'b0000) begin
      tests_failed++;
      $display("FAIL hs_release2: start=%b busy=%b ack=%b want 0 1 0000", eng_start, busy, ack);
    end
    step();
    req = 4'b0000;
    tests_run++;
    if (ack !== 4'b0001) begin
      tests_failed++;
      $display("FAIL hs_ack_third: ack=%b want 0001", ack);
    end
    step();
  endtask

  task automatic test_idle_done_block();
    int bad;
    eng_done = 1'b1;
    req = 4'b0010;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (busy !== 1'b0 || eng_start !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL idle_done_no_grant: %0d granted cycles want 0", bad);
    end
    eng_done = 1'b0;
    step();
    tests_run++;
    if (busy !== 1'b1 || eng_start !== 1'b1 || sel !== 2'd1) begin
      tests_failed++;
      $display("FAIL idle_done_release_grant: busy=%b start=%b sel=%0d want 1 1 1", busy, eng_start, sel);
    end
    req = 4'b0000;
    finish_draw();
    step();
  endtask

  task automatic test_withdraw();
    int acks;
    int bad;
    req = 4'b0010;
    step();
    step();
    req = 4'b0000;
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    acks = 0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ack == 4'b0010) acks++;
      else if (ack !== 4'b0000) bad++;
      if (c >= 2 && busy !== 1'b0) bad++;
    end
    tests_run++;
    if (acks != 1 || bad != 0) begin
      tests_failed++;
      $display("FAIL withdraw_ack_once: acks=%0d bad=%0d want 1 0", acks, bad);
    end
  endtask

  task automatic test_origin_stable();
    int bad;
    set_origin(0, 8'd5, 7'd6);
    req = 4'b0001;
    step();
    req_x = '1;
    req_y = '1;
    req = 4'b0110;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (eng_x !== 8'd5 || eng_y !== 7'd6 || sel !== 2'd0) bad++;
      step();
    end
    eng_done = 1'b1;
    step();
    if (eng_x !== 8'd5 || eng_y !== 7'd6 || sel !== 2'd0) bad++;
    eng_done = 1'b0;
    step();
    req = 4'b0000;
    tests_run++;
    if (bad != 0 || eng_x !== 8'd5 || eng_y !== 7'd6 || sel !== 2'd0 || ack !== 4'b0001) begin
      tests_failed++;
      $display("FAIL origin_stable: bad=%0d x=%0d y=%0d sel=%0d ack=%b want 0 5 6 0 0001",
               bad, eng_x, eng_y, sel, ack);
    end
    step();
    req_x = '0;
    req_y = '0;
  endtask

  task automatic test_reset_mid_draw();
    int bad;
    set_origin(2, 8'd77, 7'd11);
    req = 4'b0100;
    step();
    for (int c = 0; c < 5; c++) step();
    reset = 1'b1;
    step();
    tests_run++;
    if (eng_start !== 1'b0 || busy !== 1'b0 || sel !== 2'd0 || eng_x !== 8'd0 || eng_y !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_draw: start=%b busy=%b sel=%0d x=%0d y=%0d want 0 0 0 0 0",
               eng_start, busy, sel, eng_x, eng_y);
    end
    reset = 1'b0;
    req = 4'b0000;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (ack !== 4'b0000 || busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL reset_no_ack: %0d bad cycles want 0", bad);
    end
    set_origin(3, 8'd200, 7'd99);
    req = 4'b1000;
    step();
    tests_run++;
    if (sel !== 2'd3 || eng_x !== 8'd200 || eng_y !== 7'd99 || eng_start !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_fresh_grant: sel=%0d x=%0d y=%0d start=%b want 3 200 99 1",
               sel, eng_x, eng_y, eng_start);
    end
    step();
    finish_draw();
    req = 4'b0000;
    tests_run++;
    if (ack !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_fresh_ack: ack=%b want 1000", ack);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [SEL_W-1:0] exp_order [5];
`ifdef DRAW_SCHED_ROUND_ROBIN_EN
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    exp_order = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b1111;
    for (int d = 0; d < 5; d++) begin
      step();
      tests_run++;
      if (sel !== exp_order[d] || eng_start !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_grant%0d: sel=%0d start=%b want %0d 1", d, sel, eng_start, exp_order[d]);
      end
      step();
      finish_draw();
      tests_run++;
      if (ack !== (4'b0001 << exp_order[d])) begin
        tests_failed++;
        $display("FAIL b2b_ack%0d: ack=%b want %b", d, ack, 4'b0001 << exp_order[d]);
      end
      step();
      tests_run++;
      if (busy !== 1'b0 || eng_start !== 1'b0 || ack !== 4'b0000) begin
        tests_failed++;
        $display("FAIL b2b_idle_gap%0d: busy=%b start=%b ack=%b want 0 0 0000", d, busy, eng_start, ack);
      end
    end
    req = 4'b0000;
    step();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b1;
    req      = '0;
    req_x    = '0;
    req_y    = '0;
    eng_done = 1'b0;
    test_reset();
    test_single();
    test_handshake();
    test_idle_done_block();
    test_withdraw();
    test_origin_stable();
    test_reset_mid_draw();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
